// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: hazard sources from the pipeline in, stage enables/flushes out.
// master = pipeline side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       mem_err;
    logic [1:0] state;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, mem_err, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, mem_err, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubble, taken-branch flush,
// memory-wait freeze with timeout watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};
    localparam ctrl_t CTRL_ADV    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_d;
    logic                err_q;
    logic                err_d;
    logic                lu;
    ctrl_t               adv;
    ctrl_t               ctrl;

    // State, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            err_q    <= err_d;
        end
    end

    // Hazard detection, advance decision, next state and stage controls
    always_comb begin
        state_d = state_q;
        wait_d  = wait_cnt;
        err_d   = err_q;
        ctrl    = CTRL_FREEZE;

        lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
             ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
              (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

        if (bus.ex_branch_taken) begin
            adv = CTRL_BRANCH;
        end else if (lu) begin
            adv = CTRL_BUBBLE;
        end else begin
            adv = CTRL_ADV;
        end

        case (state_q)
            S_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    ctrl = adv;
                end
            end
            S_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    ctrl    = adv;
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (reset) begin
            ctrl = CTRL_FREEZE;
        end
    end

    assign bus.pc_en      = ctrl.pc_en;
    assign bus.ifid_en    = ctrl.ifid_en;
    assign bus.idex_en    = ctrl.idex_en;
    assign bus.exmem_en   = ctrl.exmem_en;
    assign bus.memwb_en   = ctrl.memwb_en;
    assign bus.ifid_flush = ctrl.ifid_flush;
    assign bus.idex_flush = ctrl.idex_flush;
    assign bus.mem_err    = err_q;
    assign bus.state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // Stall cycles (PC held outside reset) and branch flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_en) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ctrl.ifid_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, perf-counter sequence, and
// randomized traffic against a behavioural model (MEM_TIMEOUT = 3).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 3;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mrd;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [9:0] exp;  // {pc,ifid,idex,exmem,memwb,ifl,idfl,err,state[1:0]}
    } vec_t;

    localparam logic [9:0] E_ZERO = 10'b00000_00_0_00;
    localparam logic [9:0] E_RUN  = 10'b11111_00_0_00;
    localparam logic [9:0] E_LU   = 10'b00111_01_0_00;
    localparam logic [9:0] E_BR   = 10'b11111_11_0_00;
    localparam logic [9:0] E_FRZ1 = 10'b00000_00_0_01;
    localparam logic [9:0] E_ERR  = 10'b00000_00_1_10;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // Behavioural model state
    int          m_mode;   // 0 run, 1 waiting on memory, 2 hung
    int          m_waited;
    bit          m_err;
    int unsigned m_stall;
    int unsigned m_flush;

    vec_t tbl[$];

    pipeline_hazard_ctrl_if bus();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipeline_hazard_ctrl #(
        .WAIT_W      (8),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic rst, input int rs, input int rt, input logic urs,
                                input logic urt, input logic mrd, input int rd, input logic br,
                                input logic req, input logic rdy, input logic [9:0] exp);
        vec_t v;
        v.rst = rst; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt;
        v.mrd = mrd; v.rd = 5'(rd); v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Expected outputs for this cycle from the hazard rules, then advance the model
    task automatic model_step(input vec_t v, output logic [9:0] e);
        bit         hazard;
        logic [6:0] go;
        int         nmode;
        hazard = v.mrd && v.rd != 0 && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
        go = v.br ? 7'b1111111 : (hazard ? 7'b0011101 : 7'b1111100);
        nmode = m_mode;
        e = {7'b0, m_err, 2'(m_mode)};
        if (v.rst) begin
            m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (m_mode == 0) begin
            if (v.req && !v.rdy) begin
                nmode = 1; m_waited = 1;
            end else begin
                e[9:3] = go;
            end
        end else if (m_mode == 1) begin
            if (v.rdy) begin
                e[9:3] = go; nmode = 0; m_waited = 0;
            end else if (m_waited == TO) begin
                nmode = 2; m_err = 1;
            end else begin
                m_waited++;
            end
        end
        m_mode = nmode;
        if (!e[9]) m_stall++;
        if (e[4]) m_flush++;
    endtask

    task automatic run_cycle(input string name, input vec_t v, input bit use_tbl);
        logic [9:0] e;
        logic [9:0] got;
        @(negedge clk);
        reset               = v.rst;
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        bus.id_uses_rs      = v.urs;
        bus.id_uses_rt      = v.urt;
        bus.ex_mem_read     = v.mrd;
        bus.ex_rd           = v.rd;
        bus.ex_branch_taken = v.br;
        bus.mem_req         = v.req;
        bus.mem_ready       = v.rdy;
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check({name, ".stall_cnt"}, stall_cnt, m_stall);
        check({name, ".flush_cnt"}, flush_cnt, m_flush);
`endif
        model_step(v, e);
        got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.mem_err, bus.state};
        check(name, 32'(got), 32'(use_tbl ? v.exp : e));
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        vectors = 0; miscompares = 0;
        m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

        reset = 1'b1;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_mem_read = 0; bus.ex_rd = '0; bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.mem_ready = 0;

        //           rst rs rt urs urt mrd rd br req rdy expected
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, E_LU));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 3, 7, 1, 0, 1, 7, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 3, 7, 1, 1, 1, 7, 0, 0, 0, E_LU));
        tbl.push_back(mk(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, E_BR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 10'b11111_11_0_01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_ERR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ERR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));
        tbl.push_back(mk(0, 4, 0, 1, 0, 1, 4, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk(0, 4, 0, 1, 0, 1, 4, 0, 1, 1, 10'b00111_01_0_01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Hold reset through the first edge so the registered outputs are defined
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle($sformatf("tbl[%0d]", i), tbl[i], 1'b1);
        end

        // Load-use, branch and a 4-cycle memory access from a fresh reset
        run_cycle("perf.rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO), 1'b1);
        run_cycle("perf.lu",  mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, E_LU), 1'b1);
        run_cycle("perf.br",  mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR), 1'b1);
        run_cycle("perf.m1",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO), 1'b1);
        run_cycle("perf.m2",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1), 1'b1);
        run_cycle("perf.m3",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1), 1'b1);
        run_cycle("perf.m4",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10'b11111_00_0_01), 1'b1);
        run_cycle("perf.idle", idle, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
        check("perf.stall_total", stall_cnt, 32'd4);
        check("perf.flush_total", flush_cnt, 32'd1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v = mk($urandom_range(99) < 3, $urandom_range(3), $urandom_range(3),
                   1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3),
                   $urandom_range(99) < 15, $urandom_range(99) < 30,
                   $urandom_range(99) < 40, E_ZERO);
            run_cycle($sformatf("rnd[%0d]", n), v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the enable and synchronous-flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard sources:
- load-use data hazards, by inserting one bubble;
- taken branches, by flushing two stages;
- multi-cycle data-memory accesses, by freezing the whole pipeline, with a timeout watchdog that halts the core on a hung memory.

## Interface
Parameters:
- WAIT_W, 8, width of memory-wait counter
- MEM_TIMEOUT, 255, wait cycles before error; must satisfy 1 ≤ MEM_TIMEOUT < 2^WAIT_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush  out  1  ORed into IF/ID and ID/EX reset (bubble insert)
- mem_err  out  1  sticky memory-timeout flag
- state  out  2  FSM state (RUN=0, MEM_WAIT=1, ERR=2)

## Operation
- Outputs are combinational from current state and inputs; state, wait counter and mem_err are registered.
- Load-use hazard (lu):
  - asserted when ex_mem_read && ex_rd != 0 && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  - ex_rd == 0 never hazards.
- Advance decision, used in RUN and on the completing cycle of MEM_WAIT, in priority order:
  1. ex_branch_taken: all five enables = 1, ifid_flush = 1, idex_flush = 1. The flush overrides lu.
  2. lu: pc_en = 0, ifid_en = 0, idex_en = 1, idex_flush = 1, exmem_en = 1, memwb_en = 1.
  3. Otherwise: all enables = 1, flushes = 0.
- Freeze: all enables = 0, all flushes = 0.
- RUN:
  - If mem_req && !mem_ready: freeze, go to MEM_WAIT, wait_cnt ← 1.
  - Otherwise apply the advance decision and stay in RUN.
- MEM_WAIT:
  - If mem_ready: apply the advance decision, go to RUN, wait_cnt ← 0.
  - Else if wait_cnt == MEM_TIMEOUT: freeze, go to ERR, mem_err ← 1.
  - Else: freeze, wait_cnt ← wait_cnt + 1.
- ERR: freeze permanently; mem_err = 1 until reset.
- A branch or load-use condition arising during MEM_WAIT is held in place by the freeze and acted on in the cycle mem_ready is seen. No separate latching is needed.
- mem_ready while mem_req = 0 is ignored.

## Timing
- Reset (reset = 1 at a clk edge):
  - registered: state ← RUN, wait_cnt ← 0, mem_err ← 0;
  - outputs while reset = 1: all enables 0, all flushes 0.
- Reset mid-MEM_WAIT or in ERR returns to RUN on the next edge; an outstanding memory request is abandoned.
- Zero-cycle decision latency: enables and flushes take effect at the same clk edge that samples the inputs.
- A single-cycle memory access (mem_req && mem_ready in RUN) never enters MEM_WAIT.
- Load-use inserts exactly one bubble, because the load has moved to MEM on the next cycle.
- Taken branch: exactly 2 flushed instructions.
- A memory access lasting N cycles (mem_ready in the Nth cycle) freezes the pipeline for N−1 cycles.
- ERR is entered on the edge following the cycle where wait_cnt == MEM_TIMEOUT without mem_ready.

## Configuration
- HAZARD_PERF_CNT_EN defined adds two output ports, both reset to 0 and wrapping at 2^32:
  - stall_cnt  out  32: increments every non-reset cycle with pc_en = 0;
  - flush_cnt  out  32: increments every cycle with ifid_flush = 1.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset for 2 cycles, then idle inputs → all enables 1, flushes 0, state = 0, mem_err = 0.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs = 5, id_uses_rs = 1 → pc_en = 0, ifid_en = 0, idex_flush = 1 for one cycle; repeat with ex_rd = 0 → no stall.
- Branch and load-use in the same cycle → ifid_flush = 1, idex_flush = 1, pc_en = 1.
- mem_req = 1 with mem_ready arriving in the 4th cycle → 3 frozen cycles, advance on the 4th; a pending ex_branch_taken flushes on that cycle.
- MEM_TIMEOUT = 3, mem_ready held 0 → ERR entered after 4 wait cycles, mem_err = 1; reset clears it.
- With HAZARD_PERF_CNT_EN: run the load-use, branch and 4-cycle memory cases → stall_cnt = 4, flush_cnt = 1.
